// File: rtl/jfpjc_pkg.sv
// rtl/jfpjc_pkg.sv - shared constants, state encoding and helpers for the jfpjc frame sequencer
package jfpjc_pkg;

    localparam int HEADER_LEN_DEF = 328;
    localparam int QT_OFFSET_DEF  = 25;
    localparam int QT_ENTRIES     = 64;

    localparam logic [7:0] JPEG_EOI_HI = 8'hFF;
    localparam logic [7:0] JPEG_EOI_LO = 8'hD9;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_HEADER = 3'd1;
    localparam seq_state_t ST_SCAN   = 3'd2;
    localparam seq_state_t ST_DRAIN  = 3'd3;
    localparam seq_state_t ST_EOI0   = 3'd4;
    localparam seq_state_t ST_EOI1   = 3'd5;

    // True when addr falls in [base, base+len)
    function automatic logic in_window(input logic [8:0] addr, input int base, input int len);
        return (int'(addr) >= base) && (int'(addr) < base + len);
    endfunction

endpackage

// File: rtl/jfpjc_byte_fifo.sv
// rtl/jfpjc_byte_fifo.sv - byte FIFO with empty flag, drop-on-full and registered read port
module jfpjc_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       i_wr_en,
    input  logic [7:0] i_wr_data,
    input  logic       i_rd_en,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_empty,
    output logic       o_overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_rd_en && !w_empty;
    // A pop in the same cycle frees a slot, so a write on a full FIFO still lands
    assign w_push  = i_wr_en && (!w_full || w_pop);

    assign o_empty    = w_empty;
    assign o_overflow = i_wr_en && w_full && !w_pop;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

    // Storage array, kept free of reset so it maps onto RAM
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Read/write pointers with wrap bit for full/empty distinction
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Registered read port: data and its strobe arrive the cycle after the pop
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop) r_rd_data <= r_mem[r_rptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/jfpjc_frame_sequencer.sv
// rtl/jfpjc_frame_sequencer.sv - wraps compressor bytes into JPEG frames: header, scan data, EOI
module jfpjc_frame_sequencer
    import jfpjc_pkg::*;
#(
    parameter int HEADER_LEN   = HEADER_LEN_DEF,
    parameter int QT_OFFSET    = QT_OFFSET_DEF,
    parameter int FIFO_DEPTH   = 16,
    parameter int QUIET_CYCLES = 64
) (
    input  logic       clock,
    input  logic       nreset,
    input  logic       enable,
    input  logic       hm01b0_vsync,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       cfg_we,
    input  logic [8:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       cfg_busy,
    output logic       qt_we,
    output logic [5:0] qt_addr,
    output logic [7:0] qt_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_sof,
    output logic       out_eof,
    output logic       overflow
);

    localparam int         QW      = $clog2(QUIET_CYCLES + 1);
    localparam logic [5:0] QT_BASE = 6'(QT_OFFSET);

    logic            r_vs_meta;
    logic            r_vs_sync;
    logic            r_vs_prev;
    seq_state_t      r_state;
    logic [8:0]      r_cnt;
    logic            r_pending;
    logic            r_en_lat;
    logic [QW-1:0]   r_quiet;
    logic [7:0]      r_hdr_mem [HEADER_LEN];
    logic [7:0]      r_hdr_q;
    logic            r_hdr_v;
    logic            r_hdr_sof;
    logic            r_eoi_v;
    logic            r_eoi_last;
    logic [7:0]      r_eoi_q;
    logic            r_qt_we;
    logic [5:0]      r_qt_addr;
    logic [7:0]      r_qt_data;
    logic            r_overflow;

    logic            w_vs_rise;
    logic            w_cfg_ok;
    logic            w_qt_hit;
    logic            w_hdr_last;
    logic            w_fifo_wr;
    logic            w_fifo_rd;
    logic            w_fifo_empty;
    logic            w_fifo_ovf;
    logic [7:0]      w_fifo_data;
    logic            w_fifo_valid;

    assign w_vs_rise  = r_vs_sync && !r_vs_prev;
    assign w_cfg_ok   = cfg_we && (r_state == ST_IDLE) && (cfg_addr < 9'(HEADER_LEN));
    assign w_qt_hit   = w_cfg_ok && in_window(cfg_addr, QT_OFFSET, QT_ENTRIES);
    assign w_hdr_last = (r_cnt == 9'(HEADER_LEN - 1));
    // Bytes arriving while idle belong to no frame and are discarded outright
    assign w_fifo_wr  = in_valid && (r_state != ST_IDLE);
    assign w_fifo_rd  = (r_state == ST_SCAN) || (r_state == ST_DRAIN);

    jfpjc_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .nreset     (nreset),
        .i_wr_en    (w_fifo_wr),
        .i_wr_data  (in_data),
        .i_rd_en    (w_fifo_rd),
        .o_rd_data  (w_fifo_data),
        .o_rd_valid (w_fifo_valid),
        .o_empty    (w_fifo_empty),
        .o_overflow (w_fifo_ovf)
    );

    // Two-flop vsync synchronizer plus edge-detect history
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_vs_meta <= 1'b0;
            r_vs_sync <= 1'b0;
            r_vs_prev <= 1'b0;
        end else begin
            r_vs_meta <= hm01b0_vsync;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    // Frame state machine: header walk, scan forwarding, quiet-time drain, EOI
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 9'd0;
            r_pending <= 1'b0;
            r_en_lat  <= 1'b0;
            r_quiet   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_rise && enable) begin
                        r_state   <= ST_HEADER;
                        r_cnt     <= 9'd0;
                        r_pending <= 1'b0;
                    end
                end
                ST_HEADER: begin
                    // A frame edge during the header closes the frame as soon as the header ends
                    if (w_vs_rise) begin
                        r_pending <= 1'b1;
                        r_en_lat  <= enable;
                    end
                    if (w_hdr_last) begin
                        r_cnt     <= 9'd0;
                        r_quiet   <= '0;
                        r_pending <= 1'b0;
                        r_state   <= (r_pending || w_vs_rise) ? ST_DRAIN : ST_SCAN;
                    end else begin
                        r_cnt <= r_cnt + 9'd1;
                    end
                end
                ST_SCAN: begin
                    if (w_vs_rise) begin
                        r_state  <= ST_DRAIN;
                        r_en_lat <= enable;
                        r_quiet  <= '0;
                    end
                end
                ST_DRAIN: begin
                    // The compressor flushes its tail late, so wait for a run of silence
                    if (r_quiet == QW'(QUIET_CYCLES)) begin
                        r_state <= ST_EOI0;
                    end else if (in_valid || !w_fifo_empty) begin
                        r_quiet <= '0;
                    end else begin
                        r_quiet <= r_quiet + 1'b1;
                    end
                end
                ST_EOI0: begin
                    r_state <= ST_EOI1;
                end
                ST_EOI1: begin
                    if (r_en_lat) begin
                        r_state <= ST_HEADER;
                        r_cnt   <= 9'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                    r_pending <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Header memory write port, open only while idle
    always_ff @(posedge clock) begin
        if (w_cfg_ok) begin
            r_hdr_mem[cfg_addr] <= cfg_data;
        end
    end

    // Header memory synchronous read; contents survive reset
    always_ff @(posedge clock) begin
        r_hdr_q <= r_hdr_mem[r_cnt];
    end

    // Strobes qualifying the header and EOI byte sources
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_hdr_v    <= 1'b0;
            r_hdr_sof  <= 1'b0;
            r_eoi_v    <= 1'b0;
            r_eoi_last <= 1'b0;
            r_eoi_q    <= 8'h00;
        end else begin
            r_hdr_v    <= (r_state == ST_HEADER);
            r_hdr_sof  <= (r_state == ST_HEADER) && (r_cnt == 9'd0);
            r_eoi_v    <= (r_state == ST_EOI0) || (r_state == ST_EOI1);
            r_eoi_last <= (r_state == ST_EOI1);
            r_eoi_q    <= (r_state == ST_EOI1) ? JPEG_EOI_LO : JPEG_EOI_HI;
        end
    end

    // Mirror quant-table header writes into the compressor's table, one cycle later
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_qt_we   <= 1'b0;
            r_qt_addr <= 6'd0;
            r_qt_data <= 8'h00;
        end else begin
            r_qt_we <= w_qt_hit;
            if (w_qt_hit) begin
                r_qt_addr <= cfg_addr[5:0] - QT_BASE;
                r_qt_data <= cfg_data;
            end
        end
    end

    // Sticky overflow flag
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_ovf) begin
            r_overflow <= 1'b1;
        end
    end

    // Sources never overlap in time, so a priority select merges them
    assign out_valid = r_hdr_v || w_fifo_valid || r_eoi_v;
    assign out_data  = r_hdr_v      ? r_hdr_q     :
                       w_fifo_valid ? w_fifo_data :
                       r_eoi_v      ? r_eoi_q     : 8'h00;
    assign out_sof   = r_hdr_sof;
    assign out_eof   = r_eoi_last;
    assign cfg_busy  = (r_state != ST_IDLE);
    assign qt_we     = r_qt_we;
    assign qt_addr   = r_qt_addr;
    assign qt_data   = r_qt_data;
    assign overflow  = r_overflow;

endmodule
